// File: rtl/fp_to_fixed.sv
// fp_to_fixed: three-stage IEEE-754 to signed fixed-point (Q OUT_INT.OUT_FRAC) converter.
// It has a valid/ready stream on both sides and accepts one word per cycle.
// The optional macro FP2FX_ROUND_EN selects round-to-nearest-even on right shifts.
// Without the macro, right shifts truncate the magnitude.
module fp_to_fixed #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int BIAS      = 127,
  parameter int OUT_INT   = 16,
  parameter int OUT_FRAC  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PRECISION-1:0]         fp_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_INT+OUT_FRAC-1:0]  fixed_out,
  output logic                         ovf,
  output logic                         unf,
  output logic                         nan
);

  localparam int W    = OUT_INT + OUT_FRAC;
  localparam int MW   = FRACTION + 1;    // mantissa including hidden bit
  localparam int MAGW = W + 1;           // magnitude can reach 2^(W-1) and beyond
  localparam int LW   = MW + W + 1;      // left-shift workspace for overflow detection

  localparam logic [1:0] C_ZERO = 2'd0;
  localparam logic [1:0] C_FIN  = 2'd1;
  localparam logic [1:0] C_INF  = 2'd2;
  localparam logic [1:0] C_NAN  = 2'd3;

  localparam logic [W-1:0]    MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [MAGW-1:0] POS_LIM = MAGW'(MAX_POS);
  localparam logic [MAGW-1:0] NEG_LIM = MAGW'(MIN_NEG);

  logic adv;

  // Stage registers
  logic                 s1_valid, s2_valid;
  logic                 s1_sign, s2_sign;
  logic [1:0]           s1_cls, s2_cls;
  logic [MW-1:0]        s1_mant;
  logic signed [15:0]   s1_sh;
  logic [MAGW-1:0]      s2_mag;
  logic                 s2_big;

  // Next-state values
  logic                 sign_n;
  logic [1:0]           cls_n;
  logic [MW-1:0]        mant_n;
  logic signed [15:0]   sh_n;
  logic [EXPONENT-1:0]  exp_f, e_eff;
  logic [FRACTION-1:0]  frac_f;
  logic [MAGW-1:0]      mag_n;
  logic                 big_n;
  logic [LW-1:0]        wide;
  logic [MW-1:0]        kept;
  int                   sh_i, rsh;
  logic [W-1:0]         res_n;
  logic                 ovf_n, unf_n, nan_n;
`ifdef FP2FX_ROUND_EN
  logic                 guard, sticky;
  logic [MW-1:0]        lost_mask;
`endif

  // The whole pipeline moves together whenever the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unpack the fields, classify the operand and compute the signed shift amount.
  // NOTE: every variable gets a default at the top of a combinational block, so no latch can be inferred.
  always_comb begin
    sign_n = fp_in[PRECISION-1];
    exp_f  = fp_in[PRECISION-2 -: EXPONENT];
    frac_f = fp_in[FRACTION-1:0];
    mant_n = {(exp_f != '0), frac_f};
    e_eff  = (exp_f == '0) ? EXPONENT'(1) : exp_f;
    sh_n   = 16'(int'(e_eff) - BIAS - FRACTION + OUT_FRAC);
    cls_n  = C_FIN;
    if (&exp_f)
      cls_n = (frac_f != '0) ? C_NAN : C_INF;
    else if (exp_f == '0 && frac_f == '0)
      cls_n = C_ZERO;
  end

  // S2: shift the mantissa into fixed-point position and flag magnitudes too large to represent.
  always_comb begin
    mag_n = '0;
    big_n = 1'b0;
    wide  = '0;
    kept  = '0;
    sh_i  = int'(s1_sh);
    rsh   = -sh_i;
`ifdef FP2FX_ROUND_EN
    guard     = 1'b0;
    sticky    = 1'b0;
    lost_mask = '0;
`endif
    if (sh_i >= 0) begin
      if (sh_i > W) begin
        big_n = |s1_mant;
      end else begin
        wide  = LW'(s1_mant) << sh_i;
        big_n = |wide[LW-1:MAGW];
        mag_n = wide[MAGW-1:0];
      end
    end else begin
      if (rsh <= MW) begin
        kept = s1_mant >> rsh;
`ifdef FP2FX_ROUND_EN
        guard     = |(s1_mant & (MW'(1) << (rsh - 1)));
        lost_mask = (MW'(1) << (rsh - 1)) - MW'(1);
        sticky    = |(s1_mant & lost_mask);
`endif
      end
      mag_n = MAGW'(kept);
`ifdef FP2FX_ROUND_EN
      // A round-up may push the value past the limit; saturation in S3 catches it.
      if (guard && (sticky || kept[0]))
        mag_n = mag_n + MAGW'(1);
`endif
    end
  end

  // S3: apply the sign, saturate to the output range and derive the flags.
  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    nan_n = 1'b0;
    case (s2_cls)
      C_NAN: nan_n = 1'b1;
      C_INF: begin
        res_n = s2_sign ? MIN_NEG : MAX_POS;
        ovf_n = 1'b1;
      end
      C_FIN: begin
        if (s2_big || s2_mag > (s2_sign ? NEG_LIM : POS_LIM)) begin
          res_n = s2_sign ? MIN_NEG : MAX_POS;
          ovf_n = 1'b1;
        end else begin
          res_n = s2_sign ? -s2_mag[W-1:0] : s2_mag[W-1:0];
          unf_n = (s2_mag == '0);
        end
      end
      default: res_n = '0;
    endcase
  end

  // Valid bits and output registers: cleared by reset, advanced together on adv.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      fixed_out <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nan       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      fixed_out <= s2_valid ? res_n : '0;
      ovf       <= s2_valid && ovf_n;
      unf       <= s2_valid && unf_n;
      nan       <= s2_valid && nan_n;
    end
  end

  // Stage datapath registers: they move in lockstep with the valid bits.
  // NOTE: datapath registers have no reset; their contents only matter while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= sign_n;
      s1_cls  <= cls_n;
      s1_mant <= mant_n;
      s1_sh   <= sh_n;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_mag  <= mag_n;
      s2_big  <= big_n;
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Directed self-checking bench for fp_to_fixed in its default Q16.16 configuration.
// Expected results are hand-computed and follow FP2FX_ROUND_EN where rounding matters.
`timescale 1ns/1ps
module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] fp_in, fixed_out;
  logic        ovf, unf, nan;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OVF  = 3'b100;
  localparam logic [2:0] F_UNF  = 3'b010;
  localparam logic [2:0] F_NAN  = 3'b001;

  always #5 clk = ~clk;

  fp_to_fixed dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fixed_out (fixed_out),
    .ovf       (ovf),
    .unf       (unf),
    .nan       (nan)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one word into an empty pipeline and check latency, value and flags.
  task automatic run_vec(input string tag, input logic [31:0] fp,
                         input logic [31:0] exp_out, input logic [2:0] exp_flags);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    fp_in     = fp;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_val"}, 64'(fixed_out), 64'(exp_out));
    check({tag, "_flags"}, 64'({ovf, unf, nan}), 64'(exp_flags));
  endtask

  logic [31:0] s_vec [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  int sent, rcv;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    fp_in     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fixed_out", 64'(fixed_out), 64'd0);
    check("rst_flags", 64'({ovf, unf, nan}), 64'(F_NONE));
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed values
    run_vec("one",        32'h3F800000, 32'h00010000, F_NONE);
    run_vec("m2p5",       32'hC0200000, 32'hFFFD8000, F_NONE);
    run_vec("m32768",     32'hC7000000, 32'h80000000, F_NONE);
    run_vec("p32768",     32'h47000000, 32'h7FFFFFFF, F_OVF);
    run_vec("p65536",     32'h47800000, 32'h7FFFFFFF, F_OVF);
    run_vec("m65536",     32'hC7800000, 32'h80000000, F_OVF);
    run_vec("pinf",       32'h7F800000, 32'h7FFFFFFF, F_OVF);
    run_vec("minf",       32'hFF800000, 32'h80000000, F_OVF);
    run_vec("nan",        32'h7FC00000, 32'h00000000, F_NAN);
    run_vec("nzero",      32'h80000000, 32'h00000000, F_NONE);
    run_vec("pzero",      32'h00000000, 32'h00000000, F_NONE);
    run_vec("tiny1e6",    32'h358637BD, 32'h00000000, F_UNF);
    run_vec("ntiny1e6",   32'hB58637BD, 32'h00000000, F_UNF);
    run_vec("subnormal",  32'h00000001, 32'h00000000, F_UNF);
    run_vec("lsb",        32'h37800000, 32'h00000001, F_NONE);
    run_vec("half_lsb",   32'h37000000, 32'h00000000, F_UNF);
`ifdef FP2FX_ROUND_EN
    run_vec("point1",     32'h3DCCCCCD, 32'h0000199A, F_NONE);
    run_vec("1p5half_lsb",32'h37400000, 32'h00000001, F_NONE);
`else
    run_vec("point1",     32'h3DCCCCCD, 32'h00001999, F_NONE);
    run_vec("1p5half_lsb",32'h37400000, 32'h00000000, F_UNF);
`endif

    // Back-to-back stream with out_ready low for cycles 2-6
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 6);
      in_valid  = (sent < 8);
      fp_in     = (sent < 8) ? s_vec[sent] : 32'h0;
      #1;
      if (cyc >= 3 && cyc <= 6)
        check($sformatf("stall_in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        check($sformatf("stream_%0d", rcv), 64'(fixed_out), 64'(32'((rcv + 1) << 16)));
        check($sformatf("stream_flags_%0d", rcv), 64'({ovf, unf, nan}), 64'(F_NONE));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(rcv), 64'd8);
    repeat (4) begin
      @(negedge clk);
      check("stream_no_extra", 64'(out_valid), 64'd0);
    end

    // Reset with three words held in a stalled pipeline
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fp_in     = 32'h3F800000;
    @(negedge clk);
    fp_in = 32'h40000000;
    @(negedge clk);
    fp_in = 32'h40400000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_full", 64'(out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_fixed_out", 64'(fixed_out), 64'd0);
    check("post_rst_flags", 64'({ovf, unf, nan}), 64'(F_NONE));
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_idle_%0d", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
    end
    run_vec("post_rst", 32'h40A00000, 32'h00050000, F_NONE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
